// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serializes one command frame and collects its response.
// Optional retry-once-on-timeout behaviour is enabled by defining UART_CMD_RETRY_EN.
module uart_cmd_master #(
  parameter int WIDTH          = 8,
  parameter int ADDR_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [WIDTH-1:0]     cmd_data,
  input  logic [WIDTH-1:0]     cmd_op_a,
  input  logic [WIDTH-1:0]     cmd_op_b,
  input  logic [3:0]           cmd_fun,
  output logic [WIDTH-1:0]     tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [WIDTH-1:0]     rx_data,
  input  logic                 rx_valid,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_valid,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] frame [4];
  logic [2:0]       len;
  logic [1:0]       idx;
  logic [1:0]       exp_cnt;
  logic [1:0]       rx_cnt;
  logic [TW-1:0]    tcnt;
  logic             retry_ok;

  logic [WIDTH-1:0] new_frame [4];
  logic [2:0]       new_len;
  logic [1:0]       new_exp;

`ifdef UART_CMD_RETRY_EN
  logic retry_cnt;
  assign retry_ok = ~retry_cnt;
`else
  assign retry_ok = 1'b0;
`endif

  // Frame image built from the live command fields; captured only on accept.
  always_comb begin
    for (int i = 0; i < 4; i++) new_frame[i] = '0;
    new_len = 3'd2;
    new_exp = 2'd2;
    case (cmd_type)
      2'd0: begin
        new_frame[0] = WIDTH'(8'hAA);
        new_frame[1] = WIDTH'(cmd_addr);
        new_frame[2] = cmd_data;
        new_len      = 3'd3;
        new_exp      = 2'd0;
      end
      2'd1: begin
        new_frame[0] = WIDTH'(8'hBB);
        new_frame[1] = WIDTH'(cmd_addr);
        new_len      = 3'd2;
        new_exp      = 2'd1;
      end
      2'd2: begin
        new_frame[0] = WIDTH'(8'hCC);
        new_frame[1] = cmd_op_a;
        new_frame[2] = cmd_op_b;
        new_frame[3] = WIDTH'(cmd_fun);
        new_len      = 3'd4;
        new_exp      = 2'd2;
      end
      default: begin
        new_frame[0] = WIDTH'(8'hDD);
        new_frame[1] = WIDTH'(cmd_fun);
        new_len      = 3'd2;
        new_exp      = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      len         <= 3'd0;
      idx         <= 2'd0;
      exp_cnt     <= 2'd0;
      rx_cnt      <= 2'd0;
      tcnt        <= '0;
      for (int i = 0; i < 4; i++) frame[i] <= '0;
`ifdef UART_CMD_RETRY_EN
      retry_cnt   <= 1'b0;
`endif
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            for (int i = 0; i < 4; i++) frame[i] <= new_frame[i];
            len       <= new_len;
            exp_cnt   <= new_exp;
            idx       <= 2'd0;
            tx_data   <= new_frame[0];
            tx_valid  <= 1'b1;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
`ifdef UART_CMD_RETRY_EN
            retry_cnt <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (tx_ready) begin
            if ({1'b0, idx} == len - 3'd1) begin
              tx_valid <= 1'b0;
              rx_cnt   <= 2'd0;
              tcnt     <= '0;
              if (exp_cnt == 2'd0) begin
                state     <= DONE;
                rsp_valid <= 1'b1;
              end else begin
                state <= WAIT_RSP;
              end
            end else begin
              idx     <= idx + 2'd1;
              tx_data <= frame[idx + 2'd1];
            end
          end
        end
        WAIT_RSP: begin
          // A byte arriving on the terminal count wins over the timeout.
          if (rx_valid) begin
            tcnt <= '0;
            if (rx_cnt == 2'd0) rsp_data[WIDTH-1:0] <= rx_data;
            else                rsp_data[2*WIDTH-1:WIDTH] <= rx_data;
            if (rx_cnt + 2'd1 == exp_cnt) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 2'd1;
            end
          end else if (tcnt == T_LAST) begin
            if (retry_ok) begin
              idx      <= 2'd0;
              tx_data  <= frame[0];
              tx_valid <= 1'b1;
              rsp_data <= '0;
              rx_cnt   <= 2'd0;
              tcnt     <= '0;
              state    <= SEND;
`ifdef UART_CMD_RETRY_EN
              retry_cnt <= 1'b1;
`endif
            end else begin
              rsp_timeout <= 1'b1;
              busy        <= 1'b0;
              cmd_ready   <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: stimulus pushes expected TX bytes and responses,
// a negedge monitor pops and compares whenever the DUT transfers a byte or reports a result.
module tb_uart_cmd_master;
  localparam int W  = 8;
  localparam int AB = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = '0;
  logic [AB-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_data = '0;
  logic [W-1:0]  cmd_op_a = '0;
  logic [W-1:0]  cmd_op_b = '0;
  logic [3:0]    cmd_fun = '0;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [2*W-1:0] rsp_data;
  logic          rsp_valid;
  logic          rsp_timeout;
  logic          busy;

  always #5 clk = ~clk;

  uart_cmd_master #(.WIDTH(W), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  typedef struct packed {
    logic        is_to;
    logic [15:0] data;
  } rsp_t;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_tx.push_back(b);
  endtask

  task automatic push_rsp(input logic is_to, input logic [15:0] d);
    rsp_t r;
    r.is_to = is_to;
    r.data  = d;
    exp_rsp.push_back(r);
  endtask

  // Monitor: sampled on the falling edge, between input updates and the next active edge.
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("tx_stall_valid", 32'(tx_valid), 32'd1);
        check("tx_stall_data", 32'(tx_data), 32'(stall_data));
      end
      stall_q    <= tx_valid && !tx_ready;
      stall_data <= tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL tx_extra: got byte 0x%0h, expected no transfer", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
      end
      if (rsp_valid || rsp_timeout) begin
        if (exp_rsp.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_extra: got valid=%0b timeout=%0b data=0x%0h, expected none",
                   rsp_valid, rsp_timeout, rsp_data);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.is_to));
          check("rsp_valid", 32'(rsp_valid), 32'(!e.is_to));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] f);
    int k = 0;
    while (!cmd_ready && k < 100) begin tick(); k++; end
    check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_data = d;
    cmd_op_a = opa; cmd_op_b = opb; cmd_fun = f;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx_done();
    int k = 0;
    while ((tx_valid || exp_tx.size() != 0) && k < 200) begin tick(); k++; end
    check("tx_drained", 32'(tx_valid), 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!cmd_ready && k < 300) begin tick(); k++; end
    check("return_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // REG_WR: three back-to-back bytes, completion pulse the cycle after the last one.
    tx_ready = 1'b1;
    push_tx(8'hAA); push_tx(8'h05); push_tx(8'h3C);
    push_rsp(1'b0, 16'h0000);
    issue(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check("wr_tx_valid_b2b", 32'(tx_valid), 32'd1);
      tick();
    end
    check("wr_tx_valid_low", 32'(tx_valid), 32'd0);
    check("wr_rsp_valid_pulse", 32'(rsp_valid), 32'd1);
    wait_idle();

    // REG_RD with a stalling transmitter.
    tx_ready = 1'b0;
    push_tx(8'hBB); push_tx(8'h02);
    push_rsp(1'b0, 16'h005A);
    issue(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0);
    k = 0;
    while ((tx_valid || exp_tx.size() != 0) && k < 100) begin
      tick();
      tx_ready = !tx_ready;
      k++;
    end
    tx_ready = 1'b1;
    check("rd_tx_drained", 32'(tx_valid), 32'd0);
    send_rx(8'h5A);
    wait_idle();

    // Stray byte while idle must not disturb the held response.
    send_rx(8'h77);
    tick();
    check("idle_rsp_hold", 32'(rsp_data), 32'h005A);
    check("idle_busy", 32'(busy), 32'd0);

    // ALU_OP while a second command is offered during SEND.
    push_tx(8'hCC); push_tx(8'h10); push_tx(8'h03); push_tx(8'h02);
    push_rsp(1'b0, 16'h0030);
    issue(2'd2, 4'd0, 8'h00, 8'h10, 8'h03, 4'd2);
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 4'hF; cmd_data = 8'hEE;
    check("send_cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("send_busy", 32'(busy), 32'd1);
    tick();
    tick();
    cmd_valid = 1'b0;
    wait_tx_done();
    send_rx(8'h30);
    send_rx(8'h00);
    wait_idle();

    // ALU_OP with both response bytes non-zero and a gap between them.
    push_tx(8'hCC); push_tx(8'hFF); push_tx(8'h01); push_tx(8'h0F);
    push_rsp(1'b0, 16'h1234);
    issue(2'd2, 4'd0, 8'h00, 8'hFF, 8'h01, 4'hF);
    wait_tx_done();
    send_rx(8'h34);
    repeat (3) tick();
    send_rx(8'h12);
    wait_idle();

    // ALU_NOP: byte on the terminal count beats the timeout.
    push_tx(8'hDD); push_tx(8'h05);
    push_rsp(1'b0, 16'hCDAB);
    issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd5);
    wait_tx_done();
    repeat (TO - 2) tick();
    send_rx(8'hAB);
    check("edge_no_timeout", 32'(rsp_timeout), 32'd0);
    check("edge_busy", 32'(busy), 32'd1);
    send_rx(8'hCD);
    wait_idle();

    // ALU_NOP: one byte then silence.
    push_tx(8'hDD); push_tx(8'h00);
`ifdef UART_CMD_RETRY_EN
    push_tx(8'hDD); push_tx(8'h00);
    push_rsp(1'b1, 16'h0000);
`else
    push_rsp(1'b1, 16'h0011);
`endif
    issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd0);
    wait_tx_done();
    send_rx(8'h11);
    k = 0;
    while (!rsp_timeout && k < 200) begin tick(); k++; end
    check("timeout_seen", 32'(rsp_timeout), 32'd1);
`ifndef UART_CMD_RETRY_EN
    check("timeout_latency", 32'(k), 32'(TO - 1));
`endif
    tick();
    check("timeout_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef UART_CMD_RETRY_EN
    check("timeout_rsp_hold", 32'(rsp_data), 32'h0000);
`else
    check("timeout_rsp_hold", 32'(rsp_data), 32'h0011);
`endif

    // Reset pulse in the middle of an ALU_OP frame.
    push_tx(8'hCC); push_tx(8'h10);
    issue(2'd2, 4'd0, 8'h00, 8'h10, 8'h03, 4'd2);
    tick();
    tick();
    tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_data", 32'(rsp_data), 32'd0);

    // A fresh REG_RD after reset.
    push_tx(8'hBB); push_tx(8'h09);
    push_rsp(1'b0, 16'h00A5);
    issue(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0);
    wait_tx_done();
    send_rx(8'hA5);
    wait_idle();
    repeat (2) tick();

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
